// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and load/store.
// Data wins ties, except that a bounded streak of data grants forces a waiting fetch through.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          i_stall,
  output logic          d_stall,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [3:0]    streak_q, streak_d;
  logic [7:0]    timer_q, timer_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          err_q, err_d;
  logic          force_i_s;

  // A fetch that has watched MAX_D_STREAK data grants go by takes the next slot.
  assign force_i_s = i_req && (streak_q == STREAK_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      streak_q  <= 4'd0;
      timer_q   <= 8'd0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      timer_q   <= timer_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    timer_d   = timer_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_done_d  = i_done_q;
    d_done_d  = d_done_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        timer_d = 8'd0;
        if (d_req && !force_i_s) begin
          state_d   = BUSY_D;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          if (!i_req) begin
            streak_d = 4'd0;
          end else if (streak_q == STREAK_MAX) begin
            streak_d = STREAK_MAX;
          end else begin
            streak_d = streak_q + 4'd1;
          end
        end else if (i_req) begin
          state_d   = BUSY_I;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          streak_d  = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end

      BUSY_I, BUSY_D: begin
        if (m_ready) begin
          state_d = DONE;
          m_req_d = 1'b0;
          if (state_q == BUSY_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = m_rdata;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = m_we_q ? '0 : m_rdata;
          end
        end else if (timer_q == TIMER_LAST) begin
          // Hung memory: complete with an error so the core is not frozen forever.
          state_d = DONE;
          m_req_d = 1'b0;
          err_d   = 1'b1;
          if (state_q == BUSY_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = '0;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      DONE: begin
        state_d  = IDLE;
        i_done_d = 1'b0;
        d_done_d = 1'b0;
        err_d    = 1'b0;
        timer_d  = 8'd0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign err     = err_q;
  assign i_stall = i_req & ~i_done_q;
  assign d_stall = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants and completions,
// a negedge monitor pops and compares them as the DUT presents m_req rises and done pulses.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAXS = 4;
  localparam int TMO = 8;

  logic          clk;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_done;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          i_stall;
  logic          d_stall;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ready;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .i_stall(i_stall), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; int gap;} grant_t;
  typedef struct {logic [31:0] rdata; logic err; int lat;} done_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; int waits;} cmd_t;

  grant_t gq[$];
  done_t  iq[$];
  done_t  dq[$];
  cmd_t   icmd[$];
  cmd_t   dcmd[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int mem_waits = 0;
  logic spur = 1'b0;
  logic m_req_prev = 1'b0;
  logic [31:0] mem [logic [31:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: responds after mem_waits wait cycles (255 = never), acts at posedge+2.
  initial begin
    int cnt;
    cnt = 0;
    m_ready = 1'b0;
    m_rdata = '0;
    mem[32'h10] = 32'h0050_0093;
    mem[32'h44] = 32'h0000_1111;
    mem[32'h48] = 32'h0000_2222;
    mem[32'h4C] = 32'h0000_3333;
    mem[32'h200] = 32'h0000_7777;
    forever begin
      @(posedge clk);
      #2;
      if (m_ready) begin
        m_ready = 1'b0;
        m_rdata = '0;
        cnt = 0;
      end else if (spur) begin
        m_ready = 1'b1;
        m_rdata = 32'hDEAD_BEEF;
      end else if (m_req) begin
        if (mem_waits != 255 && cnt == mem_waits) begin
          m_ready = 1'b1;
          cnt = 0;
          if (m_we) begin
            mem[m_addr] = m_wdata;
            m_rdata = 32'hFFFF_FFFF;
          end else begin
            m_rdata = mem.exists(m_addr) ? mem[m_addr] : 32'h0;
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops expected grants on each m_req rise and expected completions on each done pulse.
  initial begin
    grant_t g;
    done_t  e;
    forever begin
      @(negedge clk);
      if (m_req && !m_req_prev) begin
        if (gq.size() == 0) begin
          chk("unexpected_grant", {32'h0, m_addr}, 64'hFFFF_FFFF);
        end else begin
          g = gq.pop_front();
          chk("grant_addr", {32'h0, m_addr}, {32'h0, g.addr});
          chk("grant_we", {63'h0, m_we}, {63'h0, g.we});
          chk("grant_wdata", {32'h0, m_wdata}, {32'h0, g.wdata});
          if (g.gap > 0) chk("grant_gap", 64'(cyc - rise_cyc), 64'(g.gap));
        end
        rise_cyc = cyc;
      end
      if (i_done) begin
        if (iq.size() == 0) begin
          chk("unexpected_i_done", {63'h0, i_done}, 64'h0);
        end else begin
          e = iq.pop_front();
          chk("i_rdata", {32'h0, i_rdata}, {32'h0, e.rdata});
          chk("i_err", {63'h0, err}, {63'h0, e.err});
          chk("i_latency", 64'(cyc - rise_cyc), 64'(e.lat));
        end
      end
      if (d_done) begin
        if (dq.size() == 0) begin
          chk("unexpected_d_done", {63'h0, d_done}, 64'h0);
        end else begin
          e = dq.pop_front();
          chk("d_rdata", {32'h0, d_rdata}, {32'h0, e.rdata});
          chk("d_err", {63'h0, err}, {63'h0, e.err});
          chk("d_latency", 64'(cyc - rise_cyc), 64'(e.lat));
        end
      end
      m_req_prev = m_req;
    end
  end

  task automatic run_i();
    cmd_t c;
    int n;
    while (icmd.size() > 0) begin
      c = icmd.pop_front();
      i_addr = c.addr;
      i_req = 1'b1;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!i_done && n < 200);
      if (n >= 200) chk("i_done_wait_expired", 64'h0, 64'h1);
    end
    i_req = 1'b0;
  endtask

  task automatic run_d();
    cmd_t c;
    int n;
    while (dcmd.size() > 0) begin
      c = dcmd.pop_front();
      mem_waits = c.waits;
      d_we = c.we;
      d_addr = c.addr;
      d_wdata = c.wdata;
      d_req = 1'b1;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!d_done && n < 200);
      if (n >= 200) chk("d_done_wait_expired", 64'h0, 64'h1);
    end
    d_req = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_req", {63'h0, m_req}, 64'h0);
    chk("rst_m_we_addr_wdata", {31'h0, m_we, m_addr}, 64'h0);
    chk("rst_m_wdata", {32'h0, m_wdata}, 64'h0);
    chk("rst_dones_err", {61'h0, i_done, d_done, err}, 64'h0);
    chk("rst_rdata", {i_rdata, d_rdata}, 64'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait fetch: m_req in cycle 1, i_done in cycle 2.
    mem_waits = 0;
    gq.push_back('{1'b0, 32'h10, 32'h0, 0});
    iq.push_back('{32'h0050_0093, 1'b0, 1});
    i_addr = 32'h10;
    i_req = 1'b1;
    #1;
    chk("t1_i_stall_waiting", {63'h0, i_stall}, 64'h1);
    @(posedge clk);
    #1;
    chk("t1_m_req_cycle1", {63'h0, m_req}, 64'h1);
    chk("t1_i_done_cycle1", {63'h0, i_done}, 64'h0);
    @(posedge clk);
    #1;
    chk("t1_i_done_cycle2", {63'h0, i_done}, 64'h1);
    chk("t1_i_stall_done", {63'h0, i_stall}, 64'h0);
    i_req = 1'b0;
    @(posedge clk);
    #1;
    chk("t1_done_one_cycle", {63'h0, i_done}, 64'h0);

    // Simultaneous requests: data first, then the fetch, then a load of the stored word.
    dcmd.push_back('{1'b1, 32'h30, 32'h30, 0});
    icmd.push_back('{1'b0, 32'h44, 32'h0, 0});
    gq.push_back('{1'b1, 32'h30, 32'h30, 0});
    gq.push_back('{1'b0, 32'h44, 32'h0, 3});
    dq.push_back('{32'h0, 1'b0, 1});
    iq.push_back('{32'h0000_1111, 1'b0, 1});
    fork
      run_i();
      run_d();
    join
    dcmd.push_back('{1'b0, 32'h30, 32'h0, 0});
    gq.push_back('{1'b0, 32'h30, 32'h0, 0});
    dq.push_back('{32'h30, 1'b0, 1});
    run_d();

    // Streak: i_req held while data keeps coming -> D,D,D,D,I,D,D,D,D,I,D.
    for (int k = 1; k <= 8; k++) begin
      dcmd.push_back('{1'b1, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k), 0});
    end
    dcmd.push_back('{1'b0, 32'h104, 32'h0, 0});
    icmd.push_back('{1'b0, 32'h48, 32'h0, 0});
    icmd.push_back('{1'b0, 32'h4C, 32'h0, 0});
    for (int k = 1; k <= 4; k++) gq.push_back('{1'b1, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k), (k == 1) ? 0 : 3});
    gq.push_back('{1'b0, 32'h48, 32'h0, 3});
    for (int k = 5; k <= 8; k++) gq.push_back('{1'b1, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k), 3});
    gq.push_back('{1'b0, 32'h4C, 32'h0, 3});
    gq.push_back('{1'b0, 32'h104, 32'h0, 3});
    for (int k = 1; k <= 8; k++) dq.push_back('{32'h0, 1'b0, 1});
    dq.push_back('{32'hA1, 1'b0, 1});
    iq.push_back('{32'h0000_2222, 1'b0, 1});
    iq.push_back('{32'h0000_3333, 1'b0, 1});
    fork
      run_i();
      run_d();
    join

    // Timeout: hung load errors TMO cycles after m_req; next request granted TMO+2 later.
    dcmd.push_back('{1'b0, 32'h200, 32'h0, 255});
    dcmd.push_back('{1'b0, 32'h10, 32'h0, 1});
    gq.push_back('{1'b0, 32'h200, 32'h0, 0});
    gq.push_back('{1'b0, 32'h10, 32'h0, TMO + 2});
    dq.push_back('{32'h0, 1'b1, TMO});
    dq.push_back('{32'h0050_0093, 1'b0, 2});
    run_d();

    // Reset while a fetch waits on a 3-wait memory: aborted, no done pulse.
    mem_waits = 3;
    gq.push_back('{1'b0, 32'h40, 32'h0, 0});
    i_addr = 32'h40;
    i_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_req && n < 20);
    chk("t5_m_req_rose", {63'h0, m_req}, 64'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    i_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t5_m_req_after_reset", {63'h0, m_req}, 64'h0);
    chk("t5_no_done_after_reset", {62'h0, i_done, err}, 64'h0);
    chk("t5_i_rdata_cleared", {32'h0, i_rdata}, 64'h0);

    // Stray m_ready in IDLE must be ignored.
    spur = 1'b1;
    @(posedge clk);
    #1;
    spur = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("t6_idle_ignores_m_ready", {61'h0, m_req, i_done, d_done}, 64'h0);
    end

    // Arbiter still serves a fresh fetch after the abort.
    mem_waits = 0;
    icmd.push_back('{1'b0, 32'h10, 32'h0, 0});
    gq.push_back('{1'b0, 32'h10, 32'h0, 0});
    iq.push_back('{32'h0050_0093, 1'b0, 1});
    run_i();
    repeat (3) @(posedge clk);
    #1;

    chk("left_grants", 64'(gq.size()), 64'h0);
    chk("left_i_done", 64'(iq.size()), 64'h0);
    chk("left_d_done", 64'(dq.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
